// File: rtl/rmii_rx_frame_ctrl.sv
// rmii_rx_frame_ctrl: frame sequencer, ring-buffer writer with rollback and descriptor FIFO; define RX_STATS_EN for per-frame counters
module rmii_rx_frame_ctrl #(
    parameter int          BUF_AW     = 12,
    parameter int          DESC_DEPTH = 4,
    parameter logic [47:0] MAC_ADDR   = 48'h00183E03E2DC,
    parameter int          MIN_LEN    = 64,
    parameter int          MAX_LEN    = 1518,
    parameter int          CHECK_WIN  = 3
) (
    input  logic              eth_clk,
    input  logic              rst,
    input  logic              rx_dv,
    input  logic              byte_dv,
    input  logic [7:0]        byte_data,
    input  logic              fcs_ok,
    output logic              buf_we,
    output logic [BUF_AW-1:0] buf_waddr,
    output logic [7:0]        buf_wdata,
    input  logic [BUF_AW:0]   buf_rd_ptr,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [BUF_AW-1:0] desc_addr,
    output logic [10:0]       desc_len,
    output logic              rx_busy
`ifdef RX_STATS_EN
    ,
    output logic [15:0]       stat_ok,
    output logic [15:0]       stat_crc,
    output logic [15:0]       stat_runt_long,
    output logic [15:0]       stat_drop
`endif
);
    localparam int DW = $clog2(DESC_DEPTH);
    localparam int WW = $clog2(CHECK_WIN + 1);
    localparam logic [WW-1:0] W_END = WW'(CHECK_WIN);
    localparam logic [DW:0] D_FULL = (DW + 1)'(DESC_DEPTH);
    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);
    typedef enum logic [2:0] {IDLE, RECV, CHECK, COMMIT, DROP} state_t;
    state_t state;
    logic rx_dv_q, ovf, filt, long_f, crc_ok, mac_m, bc_m;
    logic [BUF_AW:0] wr_ptr, frm_start, commit_ptr;
    logic [10:0] cnt, cnt_nx;
    logic [WW-1:0] win;
    logic [47:0] mac_sh;
    logic in_hdr, mac_m_nx, bc_m_nx, filt_nx, long_nx, ovf_nx, full, wr_ok, accept;
    logic [BUF_AW+10:0] fifo_mem [DESC_DEPTH];
    logic [DW:0] f_wp, f_rp;
    logic fifo_full;
    // per-byte flag evaluation; a byte that raises a flag is itself not written
    always_comb begin
        cnt_nx   = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
        mac_sh   = MAC_ADDR << {cnt[2:0], 3'b000};
        in_hdr   = cnt < 11'd6;
        mac_m_nx = mac_m & (byte_data == mac_sh[47:40]);
        bc_m_nx  = bc_m & (byte_data == 8'hFF);
        filt_nx  = filt | (in_hdr & ~mac_m_nx & ~bc_m_nx);
        long_nx  = long_f | (cnt_nx > MAX_L);
        full     = (wr_ptr - buf_rd_ptr) == {1'b1, {BUF_AW{1'b0}}};
        ovf_nx   = ovf | (~filt_nx & ~long_nx & full);
        wr_ok    = ~(filt_nx | long_nx | ovf_nx);
        accept   = crc_ok & ~ovf & ~filt & ~long_f & (cnt >= MIN_L) & ~fifo_full;
    end
    assign rx_busy    = state != IDLE;
    assign fifo_full  = (f_wp - f_rp) == D_FULL;
    assign desc_valid = f_wp != f_rp;
    assign {desc_addr, desc_len} = fifo_mem[f_rp[DW-1:0]];
    // frame sequencer: receive, check window, commit or roll back
    always_ff @(posedge eth_clk) begin
        if (rst) begin
            state <= IDLE;
            rx_dv_q <= 1'b0;
            {ovf, filt, long_f, crc_ok, mac_m, bc_m} <= '0;
            {wr_ptr, frm_start, commit_ptr} <= '0;
            cnt <= '0;
            win <= '0;
            {buf_we, buf_waddr, buf_wdata} <= '0;
        end else begin
            rx_dv_q <= rx_dv;
            buf_we <= 1'b0;
            case (state)
                IDLE: if (rx_dv & ~rx_dv_q) begin
                    state <= RECV;
                    cnt <= '0;
                    {ovf, filt, long_f, crc_ok} <= '0;
                    {mac_m, bc_m} <= 2'b11;
                    frm_start <= commit_ptr;
                end
                RECV: begin
                    if (byte_dv) begin
                        cnt <= cnt_nx;
                        {filt, long_f, ovf} <= {filt_nx, long_nx, ovf_nx};
                        if (in_hdr) {mac_m, bc_m} <= {mac_m_nx, bc_m_nx};
                        if (wr_ok) begin
                            {buf_we, buf_waddr, buf_wdata} <= {1'b1, wr_ptr[BUF_AW-1:0], byte_data};
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                    if (!rx_dv) begin
                        state <= CHECK;
                        win <= '0;
                    end
                end
                CHECK: begin
                    if (fcs_ok && win != W_END) crc_ok <= 1'b1;
                    win <= win + WW'(1);
                    if (win == W_END) state <= accept ? COMMIT : DROP;
                end
                COMMIT: begin
                    commit_ptr <= wr_ptr;
                    state <= IDLE;
                end
                DROP: begin
                    wr_ptr <= frm_start;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // descriptor FIFO; push and pop in one cycle both take effect
    always_ff @(posedge eth_clk) begin
        if (rst) begin
            f_wp <= '0;
            f_rp <= '0;
            for (int i = 0; i < DESC_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (state == COMMIT) begin
                fifo_mem[f_wp[DW-1:0]] <= {frm_start[BUF_AW-1:0], cnt - 11'd4};
                f_wp <= f_wp + (DW + 1)'(1);
            end
            if (desc_valid & desc_ready) f_rp <= f_rp + (DW + 1)'(1);
        end
    end
`ifdef RX_STATS_EN
    // one saturating increment per unfiltered frame at the end of the check window
    always_ff @(posedge eth_clk) begin
        if (rst) begin
            {stat_ok, stat_crc, stat_runt_long, stat_drop} <= '0;
        end else if (state == CHECK && win == W_END && !filt) begin
            if (!crc_ok) stat_crc <= stat_crc + {15'd0, stat_crc != 16'hFFFF};
            else if (long_f || cnt < MIN_L) stat_runt_long <= stat_runt_long + {15'd0, stat_runt_long != 16'hFFFF};
            else if (ovf || fifo_full) stat_drop <= stat_drop + {15'd0, stat_drop != 16'hFFFF};
            else stat_ok <= stat_ok + {15'd0, stat_ok != 16'hFFFF};
        end
    end
`endif
endmodule

// File: tb/tb_rmii_rx_frame_ctrl.sv
// tb_rmii_rx_frame_ctrl: scoreboard bench with a frame-level reference model
module tb_rmii_rx_frame_ctrl;
    localparam int AW = 7;
    localparam int BSZ = 1 << AW;
    localparam int DEPTH = 4;
    localparam logic [47:0] MAC = 48'h00183E03E2DC;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam int CW = 3;
    logic eth_clk = 0, rst = 1, rx_dv = 0, byte_dv = 0, fcs_ok = 0, desc_ready = 1;
    logic [7:0] byte_data = 0;
    logic [AW:0] buf_rd_ptr = '0;
    logic buf_we, desc_valid, rx_busy;
    logic [AW-1:0] buf_waddr, desc_addr;
    logic [7:0] buf_wdata;
    logic [10:0] desc_len;
`ifdef RX_STATS_EN
    logic [15:0] stat_ok, stat_crc, stat_runt_long, stat_drop;
`endif
    rmii_rx_frame_ctrl #(.BUF_AW(AW), .DESC_DEPTH(DEPTH), .MAC_ADDR(MAC), .MIN_LEN(MIN_LEN),
                         .MAX_LEN(MAX_LEN), .CHECK_WIN(CW)) dut (
        .eth_clk(eth_clk), .rst(rst), .rx_dv(rx_dv), .byte_dv(byte_dv), .byte_data(byte_data),
        .fcs_ok(fcs_ok), .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .buf_rd_ptr(buf_rd_ptr), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_addr(desc_addr), .desc_len(desc_len), .rx_busy(rx_busy)
`ifdef RX_STATS_EN
        , .stat_ok(stat_ok), .stat_crc(stat_crc), .stat_runt_long(stat_runt_long), .stat_drop(stat_drop)
`endif
    );
    always #10 eth_clk = ~eth_clk;
    int tests = 0, fails = 0;
    int wq[$];
    int dq[$];
    int commit = 0, occ = 0;
    int m_ok = 0, m_crc = 0, m_rl = 0, m_drop = 0;
    int cyc = 0, t_fall = 0, t_valid = -1;
    logic run_mon = 0, dv_prev = 0;
    logic [7:0] fb [0:2047];
    always @(posedge eth_clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask
    // monitor: compare every buffer write and every presented descriptor with the scoreboard
    always @(negedge eth_clk) if (run_mon) begin
        if (buf_we) begin
            tests++;
            if (wq.size() == 0) begin
                fails++;
                $display("FAIL write: unexpected addr=%0d data=%02h", buf_waddr, buf_wdata);
            end else begin
                int e;
                e = wq.pop_front();
                if (e != int'({buf_waddr, buf_wdata})) begin
                    fails++;
                    $display("FAIL write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                             buf_waddr, buf_wdata, e >> 8, e & 255);
                end
            end
        end
        if (desc_valid) begin
            tests++;
            if (dq.size() == 0) begin
                fails++;
                $display("FAIL desc: unexpected addr=%0d len=%0d", desc_addr, desc_len);
            end else begin
                if (dq[0] != int'({desc_addr, desc_len})) begin
                    fails++;
                    $display("FAIL desc: got addr=%0d len=%0d, expected addr=%0d len=%0d",
                             desc_addr, desc_len, dq[0] >> 11, dq[0] & 2047);
                end
                if (desc_ready) void'(dq.pop_front());
            end
        end
        if (desc_valid && !dv_prev) t_valid = cyc;
        dv_prev = desc_valid;
    end
    function automatic logic [7:0] mac_byte(input int i);
        logic [47:0] m;
        m = MAC;
        return 8'(m >> (8 * (5 - i)));
    endfunction
    task automatic wait_idle;
        int k;
        k = 0;
        while (rx_busy && k < 50) begin
            @(negedge eth_clk);
            k++;
        end
        chk("idle_timeout", int'(rx_busy), 0);
    endtask
    // kind: 0 station, 1 broadcast, 2 station with last dest byte +1, 3 random dest, 4 FF:FF:00 partial broadcast
    // fd: cycles after rx_dv falls that fcs_ok pulses (0 = never)
    task automatic send_frame(input int n, input int kind, input int fd);
        int f, lim, fr, w, used;
        bit mac_ok, bc_ok, crc, ovf, filt, lng, acc;
        for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
        for (int i = 0; i < 6 && i < n; i++) begin
            if (kind == 0 || kind == 2) fb[i] = mac_byte(i);
            if (kind == 1 || (kind == 4 && i < 2)) fb[i] = 8'hFF;
            if (kind == 4 && i == 2) fb[i] = 8'h00;
        end
        if (kind == 2 && n > 5) fb[5] = mac_byte(5) + 8'd1;
        mac_ok = 1;
        bc_ok = 1;
        f = n;
        for (int i = 0; i < 6 && i < n; i++) begin
            mac_ok &= fb[i] == mac_byte(i);
            bc_ok &= fb[i] == 8'hFF;
            if (!mac_ok && !bc_ok) begin
                f = i;
                break;
            end
        end
        used = (commit - int'(buf_rd_ptr)) & (2 * BSZ - 1);
        fr = BSZ - used;
        lim = n < f ? n : f;
        lim = lim < MAX_LEN ? lim : MAX_LEN;
        w = lim < fr ? lim : fr;
        ovf = fr < lim;
        filt = f < n;
        lng = n > MAX_LEN;
        crc = fd >= 1 && fd <= CW;
        acc = crc && !ovf && !filt && !lng && n >= MIN_LEN && occ < DEPTH;
        for (int i = 0; i < w; i++) wq.push_back((((commit + i) % BSZ) << 8) | int'(fb[i]));
        if (!filt) begin
            if (!crc) m_crc++;
            else if (n < MIN_LEN || lng) m_rl++;
            else if (ovf || occ >= DEPTH) m_drop++;
            else m_ok++;
        end
        if (acc) begin
            dq.push_back(((commit % BSZ) << 11) | (n - 4));
            commit = (commit + n) % (2 * BSZ);
            occ++;
        end
        @(posedge eth_clk); #1;
        rx_dv = 1;
        for (int i = 0; i < n; i++) begin
            @(posedge eth_clk); #1;
            byte_dv = 1;
            byte_data = fb[i];
            if ($urandom_range(0, 3) == 0) begin
                @(posedge eth_clk); #1;
                byte_dv = 0;
                byte_data = 8'($urandom);
            end
        end
        @(posedge eth_clk); #1;
        rx_dv = 0;
        byte_dv = 0;
        t_fall = cyc + 1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge eth_clk); #1;
            fcs_ok = k == fd;
            byte_dv = 1'($urandom_range(0, 1));
            byte_data = 8'($urandom);
        end
        @(posedge eth_clk); #1;
        fcs_ok = 0;
        byte_dv = 0;
        wait_idle();
        repeat (2) @(posedge eth_clk);
        #1;
    endtask
    initial begin
        repeat (3) @(posedge eth_clk);
        @(negedge eth_clk);
        chk("rst_buf_we", int'(buf_we), 0);
        chk("rst_buf_waddr", int'(buf_waddr), 0);
        chk("rst_buf_wdata", int'(buf_wdata), 0);
        chk("rst_desc_valid", int'(desc_valid), 0);
        chk("rst_desc_addr", int'(desc_addr), 0);
        chk("rst_desc_len", int'(desc_len), 0);
        chk("rst_rx_busy", int'(rx_busy), 0);
        @(posedge eth_clk); #1;
        rst = 0;
        run_mon = 1;
        send_frame(64, 0, 2);
        chk("latency", t_valid - t_fall, CW + 2);
        occ = 0;
        buf_rd_ptr = (AW + 1)'(commit);
        send_frame(64, 0, 0);
        send_frame(64, 0, 1);
        occ = 0;
        buf_rd_ptr = (AW + 1)'(commit);
        send_frame(70, 1, 3);
        occ = 0;
        buf_rd_ptr = (AW + 1)'(commit);
        send_frame(64, 2, 2);
        send_frame(64, 4, 2);
        send_frame(60, 0, 2);
        send_frame(1519, 0, 2);
        send_frame(64, 0, 4);
        send_frame(100, 0, 2);
        occ = 0;
        send_frame(64, 0, 2);
        buf_rd_ptr = (AW + 1)'(commit);
        send_frame(64, 0, 2);
        occ = 0;
        buf_rd_ptr = (AW + 1)'(commit);
        desc_ready = 0;
        repeat (5) begin
            buf_rd_ptr = (AW + 1)'(commit);
            send_frame(64, 0, 2);
        end
        repeat (4) @(posedge eth_clk);
        #1;
        chk("fifo_held_count", dq.size(), DEPTH);
        desc_ready = 1;
        repeat (8) @(posedge eth_clk);
        #1;
        occ = 0;
        for (int t = 0; t < 60; t++) begin
            int n, kind, fd, r;
            r = $urandom_range(0, 9);
            n = r == 0 ? MIN_LEN - 1 : r == 1 ? MIN_LEN : $urandom_range(1, 130);
            r = $urandom_range(0, 9);
            kind = r < 5 ? 0 : r < 7 ? 1 : r == 7 ? 2 : r == 8 ? 3 : 4;
            fd = $urandom_range(0, 9) < 7 ? $urandom_range(1, CW) : $urandom_range(0, 1) * (CW + 1);
            if ($urandom_range(0, 3) != 0) buf_rd_ptr = (AW + 1)'(commit);
            occ = 0;
            send_frame(n, kind, fd);
        end
        repeat (10) @(posedge eth_clk);
        @(negedge eth_clk);
        chk("writes_left", wq.size(), 0);
        chk("descs_left", dq.size(), 0);
`ifdef RX_STATS_EN
        chk("stat_ok", int'(stat_ok), m_ok);
        chk("stat_crc", int'(stat_crc), m_crc);
        chk("stat_runt_long", int'(stat_runt_long), m_rl);
        chk("stat_drop", int'(stat_drop), m_drop);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
